// File: rtl/vpu_alu_mul_arb.sv
// -----------------------------------------------------------------------------
// vpu_alu_mul_arb
// Shares one pipelined unsigned multiplier between NUM_REQ requesters.
// A round-robin arbiter accepts at most one request per cycle. The accepted
// request enters a LATENCY-stage pipeline. The requester ID travels with the
// product. The result leaves on a single valid/ready response channel.
// Response backpressure stalls the whole pipeline through one global enable.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid_i    per-requester request valid
//   req_ready_o    per-requester accept (one-hot or zero)
//   req_op0_i      packed operand 0, requester i at [i*OPERAND_WIDTH +: OPERAND_WIDTH]
//   req_op1_i      packed operand 1, same packing
//   rsp_valid_o    result valid
//   rsp_ready_i    downstream accepts result
//   rsp_id_o       index of the requester that owns the result
//   rsp_result_o   low OPERAND_WIDTH bits of op0*op1 (zero when not valid)
//   busy_o         any pipeline stage holds a valid entry
// -----------------------------------------------------------------------------
module vpu_alu_mul_arb #(
  parameter int NUM_REQ       = 4,
  parameter int OPERAND_WIDTH = 32,
  parameter int LATENCY       = 2,
  parameter int ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0]   req_op0_i,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0]   req_op1_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic [ID_WIDTH-1:0]                rsp_id_o,
  output logic [OPERAND_WIDTH-1:0]           rsp_result_o,
  output logic                               busy_o
);

  // Requester index reached by stepping 'off' places past 'base', wrapping.
  function automatic int wrap_idx(input int base, input int off);
    return (base + off) % NUM_REQ;
  endfunction

  logic                                  advance_s;
  logic                                  grant_found_s;
  logic                                  handshake_s;
  logic [ID_WIDTH-1:0]                   grant_idx_s;
  logic [ID_WIDTH-1:0]                   ptr_next_s;
  logic [ID_WIDTH-1:0]                   ptr_r;
  logic [OPERAND_WIDTH-1:0]              op0_sel_s;
  logic [OPERAND_WIDTH-1:0]              op1_sel_s;
  logic [OPERAND_WIDTH-1:0]              product_s;
  logic [LATENCY-1:0]                    valid_r;
  logic [LATENCY-1:0][ID_WIDTH-1:0]      id_r;
  logic [LATENCY-1:0][OPERAND_WIDTH-1:0] data_r;

  // The pipeline moves only when the output slot is empty or is being drained.
  assign advance_s   = !valid_r[LATENCY-1] || rsp_ready_i;
  assign handshake_s = advance_s && grant_found_s;

  // Round-robin search from ptr_r upward. Pick the first valid requester and its operands.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    op0_sel_s     = '0;
    op1_sel_s     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found_s && req_valid_i[wrap_idx(int'(ptr_r), k)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = ID_WIDTH'(wrap_idx(int'(ptr_r), k));
        op0_sel_s     = req_op0_i[wrap_idx(int'(ptr_r), k)*OPERAND_WIDTH +: OPERAND_WIDTH];
        op1_sel_s     = req_op1_i[wrap_idx(int'(ptr_r), k)*OPERAND_WIDTH +: OPERAND_WIDTH];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Truncating unsigned multiply: only the low OPERAND_WIDTH bits are kept.
  assign product_s = op0_sel_s * op1_sel_s;

  // Accept strobe is one-hot on the winner, and is suppressed during a stall.
  always_comb begin
    if (handshake_s) begin
      req_ready_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      req_ready_o = '0;
    end
  end

  // The next search starts just past the winner, and wraps to 0 after the last requester.
  always_comb begin
    if (grant_idx_s == ID_WIDTH'(NUM_REQ-1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + ID_WIDTH'(1);
    end
  end

  // Round-robin pointer: it moves only on an accepted request, so it is frozen during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (handshake_s) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Multiply pipeline. Every stage shifts together on advance. Bubbles are kept, not compacted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      id_r    <= '0;
      data_r  <= '0;
    end else if (advance_s) begin
      valid_r[0] <= handshake_s;
      // Stage 0 captures ID and product only on an accepted request.
      if (handshake_s) begin
        id_r[0]   <= grant_idx_s;
        data_r[0] <= product_s;
      end else begin
        id_r[0]   <= id_r[0];
        data_r[0] <= data_r[0];
      end
      for (int s = 1; s < LATENCY; s++) begin
        valid_r[s] <= valid_r[s-1];
        id_r[s]    <= id_r[s-1];
        data_r[s]  <= data_r[s-1];
      end
    end else begin
      valid_r <= valid_r;
      id_r    <= id_r;
      data_r  <= data_r;
    end
  end

  // The response channel is driven directly from the last stage's registers.
  assign rsp_valid_o  = valid_r[LATENCY-1];
  assign rsp_id_o     = id_r[LATENCY-1];
  assign rsp_result_o = valid_r[LATENCY-1] ? data_r[LATENCY-1] : '0;
  assign busy_o       = |valid_r;

endmodule

// File: tb/tb_vpu_alu_mul_arb.sv
// -----------------------------------------------------------------------------
// tb_vpu_alu_mul_arb
// Directed self-checking bench for vpu_alu_mul_arb with its default parameters.
// The parameters are NUM_REQ=4, OPERAND_WIDTH=32 and LATENCY=2.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// 1-2 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_vpu_alu_mul_arb;
  localparam int NR  = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid_i;
  logic [NR-1:0]     req_ready_o;
  logic [NR*W-1:0]   req_op0_i;
  logic [NR*W-1:0]   req_op1_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [IDW-1:0]    rsp_id_o;
  logic [W-1:0]      rsp_result_o;
  logic              busy_o;

  int n_checks;
  int n_pass;

  vpu_alu_mul_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op0_i    (req_op0_i),
    .req_op1_i    (req_op1_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_result_o (rsp_result_o),
    .busy_o       (busy_o)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_rsp(input string tag, input logic [IDW-1:0] id, input logic [W-1:0] res);
    chk_eq({tag, "_valid"}, {31'd0, rsp_valid_o}, 32'd1);
    chk_eq({tag, "_id"}, {30'd0, rsp_id_o}, {30'd0, id});
    chk_eq({tag, "_result"}, rsp_result_o, res);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op0_i[r*W +: W] = a;
    req_op1_i[r*W +: W] = b;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  logic [NR-1:0] rr_gnt [5];
  logic [W-1:0]  rr_res [4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_res = '{32'd30, 32'd44, 32'd60, 32'd78};

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    req_valid_i = '0;
    req_op0_i = '0;
    req_op1_i = '0;
    rsp_ready_i = 1'b1;
    tick;
    tick;
    chk_eq("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk_eq("rst_rsp_id", {30'd0, rsp_id_o}, 32'd0);
    chk_eq("rst_rsp_result", rsp_result_o, 32'd0);
    chk_eq("rst_req_ready", {28'd0, req_ready_o}, 32'd0);
    chk_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_n = 1'b1;
    tick;

    // ---------------- single request: 7*6 from requester 1 ----------------
    set_req(1, 32'd7, 32'd6);
    req_valid_i = 4'b0010;
    #1 chk_eq("single_ready", {28'd0, req_ready_o}, 32'h2);
    tick;
    req_valid_i = '0;
    chk_eq("single_busy_t1", {31'd0, busy_o}, 32'd1);
    chk_eq("single_valid_t1", {31'd0, rsp_valid_o}, 32'd0);
    tick;
    chk_rsp("single_t2", 2'd1, 32'd42);
    chk_eq("single_busy_t2", {31'd0, busy_o}, 32'd1);
    tick;
    chk_eq("single_valid_t3", {31'd0, rsp_valid_o}, 32'd0);
    chk_eq("single_busy_t3", {31'd0, busy_o}, 32'd0);

    // ---------------- round robin, all four continuously valid ----------------
    do_reset;
    set_req(0, 32'd10, 32'd3);
    set_req(1, 32'd11, 32'd4);
    set_req(2, 32'd12, 32'd5);
    set_req(3, 32'd13, 32'd6);
    for (int c = 0; c < 8; c++) begin
      req_valid_i = (c < 5) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 5) chk_eq("rr_ready", {28'd0, req_ready_o}, {28'd0, rr_gnt[c]});
      if (c >= 2 && c <= 6) chk_rsp("rr_rsp", IDW'((c - 2) % 4), rr_res[(c - 2) % 4]);
      if (c == 7) chk_eq("rr_drain", {31'd0, rsp_valid_o}, 32'd0);
      tick;
    end

    // ---------------- backpressure (ptr is 1) ----------------
    set_req(1, 32'd5, 32'd9);
    req_valid_i = 4'b0010;
    #1 chk_eq("bp_ready_c0", {28'd0, req_ready_o}, 32'h2);
    tick;
    set_req(3, 32'd3, 32'd4);
    req_valid_i = 4'b1000;
    #1 chk_eq("bp_ready_c1", {28'd0, req_ready_o}, 32'h8);
    tick;
    set_req(0, 32'd2, 32'd2);
    req_valid_i = 4'b0001;
    rsp_ready_i = 1'b0;
    #1;
    chk_rsp("bp_stall0", 2'd1, 32'd45);
    chk_eq("bp_stall0_ready", {28'd0, req_ready_o}, 32'd0);
    for (int s = 1; s < 3; s++) begin
      tick;
      chk_rsp("bp_stall", 2'd1, 32'd45);
      chk_eq("bp_stall_ready", {28'd0, req_ready_o}, 32'd0);
    end
    tick;
    rsp_ready_i = 1'b1;
    #1;
    chk_rsp("bp_release", 2'd1, 32'd45);
    chk_eq("bp_release_ready", {28'd0, req_ready_o}, 32'h1);
    tick;
    req_valid_i = '0;
    chk_rsp("bp_next", 2'd3, 32'd12);
    tick;
    chk_rsp("bp_last", 2'd0, 32'd4);
    tick;
    chk_eq("bp_drain_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk_eq("bp_drain_busy", {31'd0, busy_o}, 32'd0);

    // ---------------- overflow truncation (ptr is 1) ----------------
    set_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid_i = 4'b0100;
    #1 chk_eq("ovf_ready0", {28'd0, req_ready_o}, 32'h4);
    tick;
    set_req(2, 32'h0001_0000, 32'h0001_0000);
    #1 chk_eq("ovf_ready1", {28'd0, req_ready_o}, 32'h4);
    tick;
    req_valid_i = '0;
    chk_rsp("ovf_ffff", 2'd2, 32'h0000_0001);
    tick;
    chk_rsp("ovf_10000", 2'd2, 32'h0000_0000);
    tick;

    // ---------------- fairness: ptr is 3, requesters 0 and 2 ----------------
    set_req(0, 32'd3, 32'd3);
    set_req(2, 32'd4, 32'd5);
    req_valid_i = 4'b0101;
    #1 chk_eq("fair_g0", {28'd0, req_ready_o}, 32'h1);
    tick;
    #1 chk_eq("fair_g2", {28'd0, req_ready_o}, 32'h4);
    tick;
    chk_rsp("fair_rsp0", 2'd0, 32'd9);
    #1 chk_eq("fair_g0_again", {28'd0, req_ready_o}, 32'h1);
    tick;
    req_valid_i = '0;
    chk_rsp("fair_rsp2", 2'd2, 32'd20);
    tick;
    chk_rsp("fair_rsp0b", 2'd0, 32'd9);
    tick;
    chk_eq("fair_busy", {31'd0, busy_o}, 32'd0);

    // ---------------- reset mid-flight (ptr is 1) ----------------
    set_req(1, 32'd7, 32'd6);
    req_valid_i = 4'b0010;
    tick;
    set_req(2, 32'd8, 32'd8);
    req_valid_i = 4'b0100;
    tick;
    req_valid_i = '0;
    chk_eq("mid_inflight", {31'd0, rsp_valid_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk_eq("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk_eq("mid_no_stale", {31'd0, rsp_valid_o}, 32'd0);
    set_req(0, 32'd9, 32'd9);
    set_req(3, 32'd2, 32'd3);
    req_valid_i = 4'b1001;
    #1 chk_eq("mid_ptr0_grant", {28'd0, req_ready_o}, 32'h1);
    tick;
    req_valid_i = '0;
    chk_eq("mid_t1_valid", {31'd0, rsp_valid_o}, 32'd0);
    tick;
    chk_rsp("mid_t2", 2'd0, 32'd81);
    tick;
    chk_eq("mid_end_busy", {31'd0, busy_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vpu_alu_mul_arb.md
Name: vpu_alu_mul_arb

Overview:
Shares one pipelined unsigned integer multiplier between NUM_REQ requesters inside the VPU ALU, such as lanes or source ports. A round-robin arbiter grants at most one request per cycle and issues it into an internal LATENCY-stage multiply pipeline. The requester ID travels with the operands, and results return on a single valid/ready response channel. The whole pipeline stalls under response backpressure.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
OPERAND_WIDTH, 32, operand and result width in bits (VPU_PKG operand width)
LATENCY, 2, multiply pipeline depth in register stages (>=1)
ID_WIDTH, $clog2(NUM_REQ), derived; do not override

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester grant/accept (one-hot or zero)
req_op0_i  in  NUM_REQ*OPERAND_WIDTH  packed operand 0; requester i at bits [i*W +: W]
req_op1_i  in  NUM_REQ*OPERAND_WIDTH  packed operand 1, same packing
rsp_valid_o  out  1  result valid
rsp_ready_i  in  1  downstream accepts result
rsp_id_o  out  ID_WIDTH  index of the requester that owns the result
rsp_result_o  out  OPERAND_WIDTH  low OPERAND_WIDTH bits of op0*op1
busy_o  out  1  any pipeline stage holds a valid entry

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, stage id/data 0, RR pointer 0. Outputs after reset: rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, req_ready_o=0, busy_o=0.
- advance = !rsp_valid_o || rsp_ready_i. This is the single global enable: every stage shifts when advance=1 and holds when advance=0.
- Arbitration (combinational):
  - When advance=1, grant the first i with req_valid_i[i]=1, searching from ptr upward and wrapping modulo NUM_REQ.
  - req_ready_o[g]=1 for the granted index only. req_ready_o is all-zero when advance=0 or no request is valid.
  - req_ready_o may depend on req_valid_i (arbiter); requesters must not make valid depend on ready.
- Handshake: req_valid_i[g] && req_ready_o[g]. On a handshake, ptr <= (g+1) mod NUM_REQ. With no handshake, ptr holds.
- A requester must hold valid and operands stable until accepted. The block does not sample operands without a handshake.
- Stage 1 on advance:
  - valid <= handshake; id <= g.
  - data <= (op0*op1)[OPERAND_WIDTH-1:0]; unsigned, overflow truncated silently.
  - Stage 1 data loads only on a handshake.
- Stages 2..LATENCY on advance: copy the previous stage's valid, id and data. Bubbles propagate; there is no compaction.
- Last stage drives the response: rsp_valid_o = valid_last, rsp_id_o = id_last, rsp_result_o = valid_last ? data_last : 0.
- Latency: handshake in cycle T gives rsp_valid_o=1 in cycle T+LATENCY if no stall occurs. Each stalled cycle adds one cycle.
- Throughput: one result per cycle with continuous requests and rsp_ready_i=1.
- Stall: while rsp_valid_o=1 and rsp_ready_i=0, rsp_id_o and rsp_result_o are held stable, no grants are issued, and ptr is frozen.
- Simultaneous events:
  - Response accept and new grant happen in the same cycle, since advance=1.
  - Multiple valid requesters: exactly one is granted, per the RR order.
- Wrap: ptr=NUM_REQ-1 and a grant to NUM_REQ-1 gives ptr=0.
- Reset mid-operation flushes all in-flight entries. No result is emitted for requests accepted before reset.
- busy_o = OR of all stage valid bits.

Test Plan:
- Single request: req 1 with op0=7, op1=6 at T, rsp_ready=1 -> at T+2, rsp_valid=1, id=1, result=42. busy_o=1 during T+1..T+2, then 0.
- All 4 requesters valid continuously, ptr=0: grants in order 0,1,2,3,0 on consecutive cycles -> responses back-to-back with ids 0,1,2,3. Each result equals its own requester's product.
- Backpressure: rsp_ready=0 for 3 cycles while rsp_valid=1 -> rsp_id and rsp_result stable, req_ready all 0, ptr unchanged. On release, the next result appears the following cycle with no loss or duplication.
- Overflow: op0=0xFFFFFFFF, op1=0xFFFFFFFF -> result=0x00000001. op0=0x00010000, op1=0x00010000 -> result=0x00000000.
- Fairness: ptr=3, requesters 0 and 2 valid -> grant 0, ptr=1 -> next grant 2, ptr=3. Requester 2 is not starved by requester 0 re-asserting.
- Reset mid-flight: assert rst_n=0 with 2 entries in flight -> rsp_valid=0, busy=0, ptr=0 immediately. After release, no stale response is emitted and the first new request follows the T+2 latency.
